// File: rtl/timer_display_scan_if.sv
// Display-side bundle for timer_display_scan.
// The master (countdown timer / game controller) drives the digits, flags and
// state. The slave (the scanner) drives the multiplexed seven-segment pins.
interface timer_display_scan_if;
  logic       tick_10ms;
  logic [2:0] current_state;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [3:0] cs_tens;
  logic [3:0] cs_ones;
  logic       one_min_left;
  logic       ten_sec_left;
  logic       time_out;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [5:0] an_n;

  modport master (
    output tick_10ms, current_state,
    output min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones,
    output one_min_left, ten_sec_left, time_out,
    input  seg_n, dp_n, an_n
  );

  modport slave (
    input  tick_10ms, current_state,
    input  min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones,
    input  one_min_left, ten_sec_left, time_out,
    output seg_n, dp_n, an_n
  );
endinterface

// File: rtl/timer_display_scan.sv
// Multiplexed 6-digit common-anode seven-segment driver for the countdown timer.
// Shows mm.ss.cc one digit per slot, blanks the whole display in IDLE, blinks it
// during the final seconds of ATIVATED and holds it steady once the timer has
// run out or the mission has ended. All display pins are registered.
module timer_display_scan #(
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_TICKS = 25
) (
  input logic              clk,
  input logic              rst,
  timer_display_scan_if.slave bus
);

  localparam int SCAN_W  = (SCAN_DIV > 1)    ? $clog2(SCAN_DIV)    : 1;
  localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  // Game state encoding shared with the controller; 110/111 have no name and
  // are handled as IDLE.
  typedef enum logic [2:0] {
    ST_IDLE              = 3'b000,
    ST_ATIVATING         = 3'b001,
    ST_ATIVATED          = 3'b010,
    ST_DETONATING        = 3'b011,
    ST_MISSION_FAILED    = 3'b100,
    ST_MISSION_SUCCESSED = 3'b101
  } game_state_e;

  game_state_e state;

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_off_q, blink_off_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic [5:0]         an_q, an_d;

  logic       scan_wrap;
  logic       is_idle;
  logic       is_activated;
  logic       is_steady;
  logic       blink_blank;
  logic       dp_blink_off;
  logic       blank_all;
  logic       lead_zero;
  logic       dp_slot;
  logic [3:0] digit_sel;

  assign state = game_state_e'(bus.current_state);

  // Seven-segment glyphs, {g,f,e,d,c,b,a}, active low. Anything above 9 is a
  // dash so a corrupted digit is visible instead of showing a wrong number.
  function automatic logic [6:0] decode_bcd(input logic [3:0] value);
    logic [6:0] glyph;
    case (value)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b0111111;
    endcase
    return glyph;
  endfunction

  // State classification used by the blanking priority.
  always_comb begin
    is_idle      = 1'b0;
    is_activated = 1'b0;
    is_steady    = bus.time_out;
    case (state)
      ST_IDLE:              is_idle = 1'b1;
      ST_ATIVATING:         is_idle = 1'b0;
      ST_ATIVATED:          is_activated = 1'b1;
      ST_DETONATING,
      ST_MISSION_FAILED,
      ST_MISSION_SUCCESSED: is_steady = 1'b1;
      default:              is_idle = 1'b1;
    endcase
  end

  // Slot timer: each digit stays selected for SCAN_DIV clocks, then the
  // scanner moves on to the next digit, wrapping after cs_ones.
  always_comb begin
    scan_wrap  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    scan_cnt_d = scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_wrap) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q >= 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
  end

  // Blink phase: only advances on 10 ms ticks while ATIVATED; leaving
  // ATIVATED clears it even on an edge where it would have toggled.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    if (!is_activated) begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end else if (bus.tick_10ms) begin
      if (blink_cnt_q == BLINK_W'(BLINK_TICKS - 1)) begin
        blink_cnt_d = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Pick the BCD digit belonging to the slot currently being scanned.
  always_comb begin
    digit_sel = 4'h0;
    case (idx_q)
      3'd0:    digit_sel = bus.min_tens;
      3'd1:    digit_sel = bus.min_ones;
      3'd2:    digit_sel = bus.sec_tens;
      3'd3:    digit_sel = bus.sec_ones;
      3'd4:    digit_sel = bus.cs_tens;
      3'd5:    digit_sel = bus.cs_ones;
      default: digit_sel = 4'h0;
    endcase
  end

  // Blanking decisions: IDLE beats everything, a finished or timed-out game
  // is never blinked, and the final-seconds blink darkens every slot.
  always_comb begin
    blink_blank  = is_activated && !is_steady && bus.ten_sec_left && blink_off_q;
    dp_blink_off = is_activated && !is_steady && bus.one_min_left && blink_off_q;
    blank_all    = is_idle || blink_blank;
    lead_zero    = (idx_q == 3'd0) && (bus.min_tens == 4'd0);
    dp_slot      = (idx_q == 3'd1) || (idx_q == 3'd3);
  end

  // Next value of the display pins for the slot selected on this edge.
  always_comb begin
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    an_d  = 6'h3F;
    if (!blank_all && !lead_zero && (idx_q <= 3'd5)) begin
      an_d  = ~(6'b100000 >> idx_q);
      seg_d = decode_bcd(digit_sel);
      dp_d  = ~(dp_slot && !dp_blink_off);
    end
  end

  // Scan and blink state; reset parks the scanner on the first slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q  <= '0;
      idx_q       <= 3'd0;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
    end
  end

  // Registered display pins; reset turns every segment and anode off at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
      an_q  <= 6'h3F;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign bus.seg_n = seg_q;
  assign bus.dp_n  = dp_q;
  assign bus.an_n  = an_q;

endmodule
